// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register write scoreboard: retire-bus layout,
// counter width and register-file geometry.
package reg_scoreboard_pkg;

  localparam int unsigned RF_BUS_W     = 39;
  localparam int unsigned RF_WE_BIT    = 38;
  localparam int unsigned RF_WADDR_HI  = 37;
  localparam int unsigned RF_WADDR_LO  = 33;
  localparam int unsigned RF_WDATA_HI  = 32;
  localparam int unsigned RF_WDATA_LO  = 1;
  localparam int unsigned RF_VALID_BIT = 0;

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic reg_idx_t rf_waddr(input logic [RF_BUS_W-1:0] bus);
    return bus[RF_WADDR_HI:RF_WADDR_LO];
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-stage / retire-bus signal bundle between the pipeline and the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                id_valid;
  reg_idx_t            id_src1;
  reg_idx_t            id_src2;
  logic                id_src1_en;
  logic                id_src2_en;
  reg_idx_t            id_dest;
  logic                id_gr_we;
  logic                es_allowin;
  logic [RF_BUS_W-1:0] rf_bus;
  logic                flush;
  logic                id_stall;
  logic                id_fire;
  logic                sb_busy;
  logic                sb_err;

  modport master (
    output id_valid, id_src1, id_src2, id_src1_en, id_src2_en, id_dest, id_gr_we,
    output es_allowin, rf_bus, flush,
    input  id_stall, id_fire, sb_busy, sb_err
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src1_en, id_src2_en, id_dest, id_gr_we,
    input  es_allowin, rf_bus, flush,
    output id_stall, id_fire, sb_busy, sb_err
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned MaxPend = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output cnt_t cnt_o,
  output logic underflow_o
);

  localparam cnt_t MaxCnt = cnt_t'(MaxPend);

  cnt_t cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; clear wins over both.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != MaxCnt) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign underflow_o = dec_i & ~inc_i & ~clr_i & (cnt_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: per-register pending-write counters that stall ID
// on RAW hazards and on a destination already at the in-flight limit.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_PEND = 4
) (
  input logic             clk,
  input logic             reset,
  reg_scoreboard_if.slave sb
);

  localparam cnt_t MaxCnt = cnt_t'(MAX_PEND);

  cnt_t                  cnt [NUM_REGS];
  logic [NUM_REGS-1:1]   inc, dec, underflow, nz;
  logic                  hazard, issue_ev, retire_ev;
  logic                  rf_we, rf_valid;
  reg_idx_t              rf_addr;
  logic                  err_q, err_d;
  logic                  unused_wdata;

  assign rf_we        = sb.rf_bus[RF_WE_BIT];
  assign rf_valid     = sb.rf_bus[RF_VALID_BIT];
  assign rf_addr      = rf_waddr(sb.rf_bus);
  assign unused_wdata = ^sb.rf_bus[RF_WDATA_HI:RF_WDATA_LO];

  // r0 is hardwired: never tracked, always reads as zero.
  assign cnt[0] = '0;

  always_comb begin
    hazard = (sb.id_src1_en && (cnt[sb.id_src1] != '0))
           | (sb.id_src2_en && (cnt[sb.id_src2] != '0))
           | (sb.id_gr_we && (sb.id_dest != '0) && (cnt[sb.id_dest] == MaxCnt));
  end

  assign sb.id_stall = sb.id_valid & (hazard | sb.flush);
  assign sb.id_fire  = sb.id_valid & ~hazard & ~sb.flush & sb.es_allowin;

  assign issue_ev  = sb.id_fire & sb.id_gr_we & (sb.id_dest != '0);
  assign retire_ev = rf_valid & rf_we & (rf_addr != '0) & ~sb.flush;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc[i] = issue_ev  && (sb.id_dest == reg_idx_t'(i));
      dec[i] = retire_ev && (rf_addr == reg_idx_t'(i));
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(
      .MaxPend (MAX_PEND)
    ) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .inc_i       (inc[g]),
      .dec_i       (dec[g]),
      .clr_i       (sb.flush),
      .cnt_o       (cnt[g]),
      .underflow_o (underflow[g])
    );
    assign nz[g] = (cnt[g] != '0);
  end

  // Sticky until reset; flush does not clear it.
  assign err_d = err_q | (|underflow);

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign sb.sb_busy = |nz;
  assign sb.sb_err  = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized + directed bench for reg_scoreboard with a per-cycle expectation
// queue filled by the driver and drained by an independent monitor.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int MaxPend = 4;

  typedef struct {
    logic stall;
    logic fire;
    logic busy;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(
    .MAX_PEND (MaxPend)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  exp_t exp_q[$];
  int   cnt_m[32];
  bit   err_m;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cmp(input string nm, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: checks every cycle that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("id_stall", sb_if.id_stall, e.stall);
        cmp("id_fire",  sb_if.id_fire,  e.fire);
        cmp("sb_busy",  sb_if.sb_busy,  e.busy);
        cmp("sb_err",   sb_if.sb_err,   e.err);
      end
    end
  end

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
  endfunction

  // One cycle of stimulus; expected outputs come from the model's counts.
  task automatic apply(input bit v, input int s1, input bit s1e, input int s2, input bit s2e,
                       input int d, input bit we, input bit al,
                       input bit rwe, input int ra, input bit rv, input bit fl);
    exp_t e;
    bit   hz, issue, ret, busy;
    @(negedge clk);
    sb_if.id_valid   = v;
    sb_if.id_src1    = s1[4:0];
    sb_if.id_src1_en = s1e;
    sb_if.id_src2    = s2[4:0];
    sb_if.id_src2_en = s2e;
    sb_if.id_dest    = d[4:0];
    sb_if.id_gr_we   = we;
    sb_if.es_allowin = al;
    sb_if.rf_bus     = {rwe, ra[4:0], 32'($urandom), rv};
    sb_if.flush      = fl;
    hz = (s1e && cnt_m[s1] != 0) || (s2e && cnt_m[s2] != 0) ||
         (we && d != 0 && cnt_m[d] == MaxPend);
    busy = 1'b0;
    for (int i = 1; i < 32; i++) if (cnt_m[i] != 0) busy = 1'b1;
    e.stall = v && (hz || fl);
    e.fire  = v && !hz && !fl && al;
    e.busy  = busy;
    e.err   = err_m;
    exp_q.push_back(e);
    if (fl) begin
      model_clear();
    end else begin
      issue = e.fire && we && d != 0;
      ret   = rv && rwe && ra != 0;
      if (!(issue && ret && d == ra)) begin
        if (issue) cnt_m[d]++;
        if (ret) begin
          if (cnt_m[ra] == 0) err_m = 1'b1;
          else cnt_m[ra]--;
        end
      end
    end
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sb_if.id_valid = 1'b0;
    sb_if.flush    = 1'b0;
    sb_if.rf_bus   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    err_m = 1'b0;
  endtask

  task automatic random_run(input int n);
    int s1, s2, d, ra, r;
    bit v, s1e, s2e, we, al, rwe, rv, fl;
    for (int i = 0; i < n; i++) begin
      v   = $urandom_range(0, 3) != 0;
      s1  = $urandom_range(0, 31);
      s2  = $urandom_range(0, 31);
      s1e = $urandom_range(0, 2) == 0;
      s2e = $urandom_range(0, 3) == 0;
      d   = $urandom_range(0, 8);
      we  = $urandom_range(0, 3) != 0;
      al  = $urandom_range(0, 3) != 0;
      fl  = $urandom_range(0, 40) == 0;
      rwe = 1'b0;
      rv  = $urandom_range(0, 1);
      ra  = $urandom_range(0, 31);
      r   = $urandom_range(1, 8);
      // Retire only registers with writes outstanding; r0 retires are harmless.
      if ($urandom_range(0, 1) == 1 && cnt_m[r] > 0) begin
        rwe = 1'b1;
        rv  = 1'b1;
        ra  = r;
      end else if ($urandom_range(0, 7) == 0) begin
        rwe = 1'b1;
        rv  = 1'b1;
        ra  = 0;
      end
      apply(v, s1, s1e, s2, s2e, d, we, al, rwe, ra, rv, fl);
    end
  endtask

  initial begin
    sb_if.id_valid   = 1'b0;
    sb_if.id_src1    = '0;
    sb_if.id_src2    = '0;
    sb_if.id_src1_en = 1'b0;
    sb_if.id_src2_en = 1'b0;
    sb_if.id_dest    = '0;
    sb_if.id_gr_we   = 1'b0;
    sb_if.es_allowin = 1'b0;
    sb_if.rf_bus     = '0;
    sb_if.flush      = 1'b0;
    err_m = 1'b0;
    model_clear();
    do_reset();

    // Reset state, idle ID and a hazard-free read
    idle();
    apply(1, 5, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0);

    // RAW on r5: stall until the cycle after its retire
    apply(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    repeat (3) apply(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply(1, 5, 1, 0, 0, 0, 0, 1, 1, 5, 1, 0);
    apply(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // In-flight limit on r7
    repeat (4) apply(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 1, 0);
    apply(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    repeat (4) apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 1, 0);
    idle();

    // Same-cycle issue/retire on r3, then split across r3/r4
    apply(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 3, 1, 1, 1, 3, 1, 0);
    apply(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 3, 1, 1, 1, 4, 1, 0);
    apply(1, 4, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 4, 1, 0, 0, 1, 1, 3, 1, 0);
    apply(1, 0, 0, 3, 1, 0, 0, 1, 1, 3, 1, 0);
    apply(1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 0);

    // Flush with pending r1/r2/r30 and a valid ID instruction
    apply(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 30, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 11, 1, 1, 1, 2, 1, 1);
    apply(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    idle();

    // Retire underflow on r9: sticky through later traffic
    apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 1, 0);
    random_run(60);
    apply(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1);
    idle();

    // Reset mid-operation, then long random traffic with a reset in between
    do_reset();
    idle();
    random_run(300);
    do_reset();
    idle();
    random_run(300);
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
